shift_pipe_n: RTL and testbench

Parametrised, pipelined N-bit barrel shifter. It extends the 32-bit combinational shifter with logical, arithmetic and rotate modes, configurable width and register depth, and a valid/ready handshake with backpressure. It sits between the operand-select stage and the ALU result mux, so shift operations can be retimed away from the single-cycle ALU path.

---
 rtl/shift_pipe_n.sv | 153 +++++++++++++++
 tb/tb_shift_pipe_n.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe_n.sv
// Pipelined N-bit barrel shifter (SLL/SRL/SRA/ROR) with tag passthrough and zero flag.
// Latency: exactly PIPE cycles from input transfer to OUT_VALID when not stalled.
// Backpressure: one global enable; a held, unaccepted output freezes every stage and drops IN_READY.
module shift_pipe_n #(
    parameter int WIDTH = 32,
    parameter int PIPE  = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] D,
    input  logic [31:0]      S,
    input  logic [1:0]       MODE,
    input  logic [4:0]       TAG,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Y,
    output logic             Z,
    output logic [4:0]       TAG_OUT
);
    localparam int LOG2W = $clog2(WIDTH);
    localparam int BASE  = LOG2W / PIPE;
    localparam int REM   = LOG2W % PIPE;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    localparam logic [WIDTH-1:0] ONES = '1;

    // First mux level handled by stage k; earlier stages absorb the remainder levels.
    function automatic int stage_lo(input int k);
        return k * BASE + ((k < REM) ? k : REM);
    endfunction

    // One mux level: shift by 2**lvl when that bit of the amount is set.
    function automatic logic [WIDTH-1:0] shift_level(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       mode,
        input logic             sign,
        input logic [LOG2W-1:0] sh,
        input int               lvl
    );
        logic [LOG2W-1:0] bits;
        logic [WIDTH-1:0] res;
        int               amt;
        bits = sh >> lvl;
        amt  = 1 << lvl;
        res  = d;
        if (bits[0]) begin
            case (mode)
                MODE_SLL: res = d << amt;
                MODE_SRL: res = d >> amt;
                MODE_SRA: res = (d >> amt) | (sign ? ~(ONES >> amt) : '0);
                default:  res = (d >> amt) | (d << (WIDTH - amt));
            endcase
        end
        return res;
    endfunction

    // Pipeline registers, index PIPE-1 is the output register.
    logic [WIDTH-1:0] r_dat  [PIPE];
    logic [LOG2W-1:0] r_sh   [PIPE];
    logic [1:0]       r_mode [PIPE];
    logic [4:0]       r_tag  [PIPE];
    logic             r_ovf  [PIPE];
    logic             r_sign [PIPE];
    logic             r_vld  [PIPE];

    // Stage inputs: ports for stage 0, previous register otherwise.
    logic [WIDTH-1:0] w_src_dat  [PIPE];
    logic [LOG2W-1:0] w_src_sh   [PIPE];
    logic [1:0]       w_src_mode [PIPE];
    logic [4:0]       w_src_tag  [PIPE];
    logic             w_src_ovf  [PIPE];
    logic             w_src_sign [PIPE];
    logic             w_src_vld  [PIPE];

    logic w_en;

    assign w_en      = !r_vld[PIPE-1] || OUT_READY;
    assign IN_READY  = w_en;
    assign OUT_VALID = r_vld[PIPE-1];
    assign Y         = r_dat[PIPE-1];
    assign TAG_OUT   = r_tag[PIPE-1];
    assign Z         = (r_dat[PIPE-1] == '0);

    for (genvar k = 0; k < PIPE; k++) begin : g_stage
        localparam int LO = stage_lo(k);
        localparam int HI = stage_lo(k + 1);

        logic [WIDTH-1:0] w_lvl_dat;
        logic [WIDTH-1:0] w_nxt_dat;

        if (k == 0) begin : g_head
            assign w_src_dat[k]  = D;
            assign w_src_sh[k]   = S[LOG2W-1:0];
            assign w_src_mode[k] = MODE;
            assign w_src_tag[k]  = TAG;
            assign w_src_ovf[k]  = |S[31:LOG2W];
            assign w_src_sign[k] = D[WIDTH-1];
            assign w_src_vld[k]  = IN_VALID;
        end else begin : g_body
            assign w_src_dat[k]  = r_dat[k-1];
            assign w_src_sh[k]   = r_sh[k-1];
            assign w_src_mode[k] = r_mode[k-1];
            assign w_src_tag[k]  = r_tag[k-1];
            assign w_src_ovf[k]  = r_ovf[k-1];
            assign w_src_sign[k] = r_sign[k-1];
            assign w_src_vld[k]  = r_vld[k-1];
        end

        // Apply this stage's share of the log-shifter mux levels.
        always_comb begin
            w_lvl_dat = w_src_dat[k];
            for (int j = LO; j < HI; j++) begin
                w_lvl_dat = shift_level(w_lvl_dat, w_src_mode[k], w_src_sign[k], w_src_sh[k], j);
            end
        end

        // Out-of-range amounts saturate in the last stage; rotate uses the amount modulo WIDTH.
        if (k == PIPE - 1) begin : g_tail
            assign w_nxt_dat = (w_src_ovf[k] && (w_src_mode[k] != MODE_ROR))
                             ? (((w_src_mode[k] == MODE_SRA) && w_src_sign[k]) ? ONES : '0)
                             : w_lvl_dat;
        end else begin : g_mid
            assign w_nxt_dat = w_lvl_dat;
        end

        // Stage register: cleared by reset, advances only on the global enable.
        always_ff @(posedge CLK) begin
            if (RST) begin
                r_vld[k]  <= 1'b0;
                r_dat[k]  <= '0;
                r_sh[k]   <= '0;
                r_mode[k] <= '0;
                r_tag[k]  <= '0;
                r_ovf[k]  <= 1'b0;
                r_sign[k] <= 1'b0;
            end else if (w_en) begin
                r_vld[k]  <= w_src_vld[k];
                r_dat[k]  <= w_nxt_dat;
                r_sh[k]   <= w_src_sh[k];
                r_mode[k] <= w_src_mode[k];
                r_tag[k]  <= w_src_tag[k];
                r_ovf[k]  <= w_src_ovf[k];
                r_sign[k] <= w_src_sign[k];
            end
        end
    end
endmodule

// File: tb/tb_shift_pipe_n.sv
// Bench for shift_pipe_n: three configurations (32/2, 16/1, 64/6) driven one at a time.
// Expected results come from a per-bit reference model and hand-derived directed constants.
// A queue scoreboard checks order, data, tag and zero flag of every output transfer.
module tb_shift_pipe_n;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] d;
    logic [31:0] s;
    logic [1:0]  mode;
    logic [4:0]  tag;
    int          sel;
    int          cur_w;
    int          cur_p;

    always #5 clk = ~clk;

    logic        iv0, iv1, iv2;
    logic        ir0, ir1, ir2;
    logic        ov0, ov1, ov2;
    logic        z0, z1, z2;
    logic [31:0] y0;
    logic [15:0] y1;
    logic [63:0] y2;
    logic [4:0]  t0, t1, t2;

    assign iv0 = in_valid && (sel == 0);
    assign iv1 = in_valid && (sel == 1);
    assign iv2 = in_valid && (sel == 2);

    shift_pipe_n #(.WIDTH(32), .PIPE(2)) u_dut32 (
        .CLK(clk), .RST(rst), .IN_VALID(iv0), .IN_READY(ir0), .D(d[31:0]), .S(s),
        .MODE(mode), .TAG(tag), .OUT_VALID(ov0), .OUT_READY(out_ready), .Y(y0), .Z(z0), .TAG_OUT(t0));
    shift_pipe_n #(.WIDTH(16), .PIPE(1)) u_dut16 (
        .CLK(clk), .RST(rst), .IN_VALID(iv1), .IN_READY(ir1), .D(d[15:0]), .S(s),
        .MODE(mode), .TAG(tag), .OUT_VALID(ov1), .OUT_READY(out_ready), .Y(y1), .Z(z1), .TAG_OUT(t1));
    shift_pipe_n #(.WIDTH(64), .PIPE(6)) u_dut64 (
        .CLK(clk), .RST(rst), .IN_VALID(iv2), .IN_READY(ir2), .D(d), .S(s),
        .MODE(mode), .TAG(tag), .OUT_VALID(ov2), .OUT_READY(out_ready), .Y(y2), .Z(z2), .TAG_OUT(t2));

    logic        in_ready_m, out_valid_m, z_m;
    logic [63:0] y_m;
    logic [4:0]  tag_out_m;

    always_comb begin
        in_ready_m = 1'b0; out_valid_m = 1'b0; z_m = 1'b0; y_m = '0; tag_out_m = '0;
        case (sel)
            0: begin in_ready_m = ir0; out_valid_m = ov0; z_m = z0; y_m = {32'd0, y0}; tag_out_m = t0; end
            1: begin in_ready_m = ir1; out_valid_m = ov1; z_m = z1; y_m = {48'd0, y1}; tag_out_m = t1; end
            default: begin in_ready_m = ir2; out_valid_m = ov2; z_m = z2; y_m = y2; tag_out_m = t2; end
        endcase
    end

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] exp_y[$];
    logic [4:0]  exp_tag[$];
    logic [4:0]  emitted[$];
    logic        ready_base;
    logic        last_acc_in;
    logic        stall_arm;
    logic        stall_seen;
    int          stall_left;
    logic [63:0] prev_y;
    logic [4:0]  prev_tag;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h (width %0d)", name, obs, exp, cur_w);
    endtask

    // Reference: each result bit is picked from the operand according to the mode rules.
    function automatic logic [63:0] model(input logic [63:0] din, input logic [31:0] sa,
                                          input logic [1:0] m, input int w);
        logic [63:0] res;
        int          amt;
        int          src;
        logic        ovf;
        res = '0;
        amt = int'(sa % w);
        ovf = (sa >= w);
        for (int i = 0; i < w; i++) begin
            case (m)
                2'b00: res[i] = (!ovf && i >= amt) ? din[i-amt] : 1'b0;
                2'b01: res[i] = (!ovf && i + amt < w) ? din[i+amt] : 1'b0;
                2'b10: begin
                    src    = ovf ? w : i + amt;
                    res[i] = (src < w) ? din[src] : din[w-1];
                end
                default: res[i] = din[(i + amt) % w];
            endcase
        end
        return res;
    endfunction

    function automatic logic [63:0] wmask(input int w);
        logic [63:0] one;
        one = 64'd1;
        return (w == 64) ? '1 : ((one << w) - 64'd1);
    endfunction

    // One clock: sample transfers mid-cycle, update scoreboard, advance to next falling edge.
    task automatic tick();
        out_ready = (stall_left > 0) ? 1'b0 : ready_base;
        #1;
        last_acc_in = 1'b0;
        if (rst) begin
            exp_y.delete();
            exp_tag.delete();
        end else begin
            if (stall_left > 0) begin
                stall_seen = 1'b1;
                chk("bp_in_ready", {63'd0, in_ready_m}, 64'd0);
                chk("bp_out_valid", {63'd0, out_valid_m}, 64'd1);
                if (stall_left < 3) begin
                    chk("bp_y_hold", y_m, prev_y);
                    chk("bp_tag_hold", {59'd0, tag_out_m}, {59'd0, prev_tag});
                end
                stall_left--;
            end
            if (out_valid_m && out_ready) begin
                chk("emit_expected", {63'd0, exp_y.size() > 0}, 64'd1);
                if (exp_y.size() > 0) begin
                    chk("y", y_m, exp_y[0]);
                    chk("tag_out", {59'd0, tag_out_m}, {59'd0, exp_tag[0]});
                    chk("z", {63'd0, z_m}, {63'd0, exp_y[0] == 64'd0});
                    emitted.push_back(tag_out_m);
                    void'(exp_y.pop_front());
                    void'(exp_tag.pop_front());
                    if (stall_arm) begin
                        stall_arm  = 1'b0;
                        stall_left = 3;
                    end
                end
            end
            if (in_valid && in_ready_m) begin
                last_acc_in = 1'b1;
                exp_y.push_back(model(d, s, mode, cur_w));
                exp_tag.push_back(tag);
            end
        end
        prev_y   = y_m;
        prev_tag = tag_out_m;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send();
        int n;
        n = 0;
        in_valid    = 1'b1;
        last_acc_in = 1'b0;
        while (!last_acc_in && n < 50) begin
            tick();
            n++;
        end
        chk("send_accepted", {63'd0, last_acc_in}, 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        ready_base = 1'b1;
        in_valid   = 1'b0;
        while (exp_y.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain_empty", 64'(exp_y.size()), 64'd0);
        chk("drain_idle", {63'd0, out_valid_m}, 64'd0);
    endtask

    task automatic rand_op();
        int r;
        d    = {$urandom, $urandom};
        mode = 2'($urandom_range(0, 3));
        tag  = 5'($urandom_range(0, 31));
        r    = $urandom_range(0, 9);
        if (r < 7)      s = 32'($urandom_range(0, cur_w - 1));
        else if (r < 9) s = $urandom;
        else            s = 32'(cur_w + $urandom_range(0, 3));
    endtask

    task automatic directed(input string name, input logic [63:0] dd, input logic [31:0] ss,
                            input logic [1:0] mm, input logic [4:0] tt, input logic [63:0] ey);
        int n;
        ready_base = 1'b1;
        d = dd; s = ss; mode = mm; tag = tt;
        send();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid_m && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_vld"}, {63'd0, out_valid_m}, 64'd1);
        chk({name, "_y"}, y_m, ey);
        chk({name, "_z"}, {63'd0, z_m}, {63'd0, ey == 64'd0});
        chk({name, "_tag"}, {59'd0, tag_out_m}, {59'd0, tt});
        drain();
    endtask

    task automatic run_suite();
        logic [63:0] msk, top, one, dm;
        logic [9:0]  pat;
        logic        ov_log [0:31];
        logic        any_ov;
        int          lat;

        one = 64'd1;
        msk = wmask(cur_w);
        top = one << (cur_w - 1);

        // Reset held two cycles with IN_VALID high.
        ready_base = 1'b0; stall_arm = 1'b0; stall_left = 0;
        rst = 1'b1; in_valid = 1'b1; d = {$urandom, $urandom}; s = 32'd1; mode = 2'b00; tag = 5'd9;
        tick(); tick();
        chk("rst_out_valid", {63'd0, out_valid_m}, 64'd0);
        chk("rst_y", y_m, 64'd0);
        chk("rst_z", {63'd0, z_m}, 64'd1);
        chk("rst_tag", {59'd0, tag_out_m}, 64'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_in_ready", {63'd0, in_ready_m}, 64'd1);

        // First-result latency.
        ready_base = 1'b1;
        rand_op();
        send();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid_m && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", 64'(lat), 64'(cur_p));
        drain();

        // Modes on a value with both end bits set, shift by 4.
        dm = top | one;
        directed("sll4", dm, 32'd4, 2'b00, 5'd3, 64'h10);
        directed("srl4", dm, 32'd4, 2'b01, 5'd3, one << (cur_w - 5));
        directed("sra4", dm, 32'd4, 2'b10, 5'd3, msk & ~(msk >> 5));
        directed("ror4", dm, 32'd4, 2'b11, 5'd3, (one << (cur_w - 4)) | (one << (cur_w - 5)));

        // Overflowing amounts and zero amount.
        directed("ovf_sll", top, 32'(cur_w), 2'b00, 5'd4, 64'd0);
        directed("ovf_sra", top, 32'(cur_w), 2'b10, 5'd5, msk);
        directed("ovf_ror", top, 32'(cur_w), 2'b11, 5'd6, top);
        directed("ovf_srl", msk, 32'h0001_0001, 2'b01, 5'd7, 64'd0);
        dm = {$urandom, $urandom} & msk;
        directed("zero_sra", dm, 32'd0, 2'b10, 5'd8, dm);
        directed("zero_ror", dm, 32'd0, 2'b11, 5'd10, dm);

        // Backpressure: stall three cycles after the first of six results.
        emitted.delete();
        stall_arm = 1'b1; stall_seen = 1'b0; ready_base = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            rand_op();
            tag = 5'(t);
            send();
        end
        drain();
        chk("bp_stalled", {63'd0, stall_seen}, 64'd1);
        chk("bp_count", 64'(emitted.size()), 64'd6);
        for (int i = 0; i < emitted.size() && i < 6; i++) begin
            chk("bp_order", {59'd0, emitted[i]}, 64'(i + 1));
        end

        // Bubbles at full throughput.
        pat = 10'b1101101111;
        ready_base = 1'b1;
        for (int c = 0; c < 10 + cur_p; c++) begin
            rand_op();
            in_valid  = (c < 10) ? pat[9-c] : 1'b0;
            ov_log[c] = out_valid_m;
            tick();
        end
        chk("pat_lead", {63'd0, ov_log[0]}, 64'd0);
        for (int c = 0; c < 10; c++) begin
            chk("pat_vld", {63'd0, ov_log[c + cur_p]}, {63'd0, pat[9-c]});
        end
        drain();

        // Random traffic with random backpressure.
        for (int c = 0; c < 150; c++) begin
            rand_op();
            in_valid   = ($urandom_range(0, 3) != 0);
            ready_base = ($urandom_range(0, 9) < 7);
            tick();
        end
        drain();

        // Reset while operations are in flight.
        ready_base = 1'b0;
        rand_op(); send();
        rand_op(); in_valid = 1'b1; tick();
        rand_op(); rst = 1'b1; tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("mid_rst_out_valid", {63'd0, out_valid_m}, 64'd0);
        ready_base = 1'b1; any_ov = 1'b0;
        for (int c = 0; c < 8; c++) begin
            any_ov = any_ov | out_valid_m;
            tick();
        end
        chk("mid_rst_quiet", {63'd0, any_ov}, 64'd0);
        directed("fresh_srl3", top, 32'd3, 2'b01, 5'd17, one << (cur_w - 4));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; d = '0; s = '0; mode = '0; tag = '0;
        sel = 0; cur_w = 32; cur_p = 2;
        ready_base = 1'b0; stall_arm = 1'b0; stall_seen = 1'b0; stall_left = 0;
        prev_y = '0; prev_tag = '0; last_acc_in = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            sel   = c;
            cur_w = (c == 0) ? 32 : (c == 1) ? 16 : 64;
            cur_p = (c == 0) ? 2  : (c == 1) ? 1  : 6;
            run_suite();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end
endmodule
